// File: rtl/laser_pkg.sv
// Shared types and constants for the laser controller slice.
package laser_pkg;

  localparam int unsigned LASER_R_WIDTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StExtend,
    StHold,
    StCooldown
  } laser_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/laser_if.sv
// Signal bundle between the game logic (master) and the laser controller (slave).
interface laser_if;
  import laser_pkg::*;

  logic                     frame_tick;
  logic                     fire;
  logic [1:0]               quadrant_sel;
  logic                     hit;
  logic                     laser_active;
  logic [LASER_R_WIDTH-1:0] laser_r;
  logic [1:0]               laser_quadrant;
  logic                     fire_ready;
  logic                     shot_done;

  modport master (
    output frame_tick, fire, quadrant_sel, hit,
    input  laser_active, laser_r, laser_quadrant, fire_ready, shot_done
  );

  modport slave (
    input  frame_tick, fire, quadrant_sel, hit,
    output laser_active, laser_r, laser_quadrant, fire_ready, shot_done
  );

endinterface

// File: rtl/laser_frame_counter.sv
// Clearable frame_tick counter; o_done flags the tick that reaches the terminal count.
module laser_frame_counter #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_tick,
  input  logic             i_clear,
  input  logic [Width-1:0] i_last,
  output logic             o_done
);

  logic [Width-1:0] r_count;

  // i_last is terminal count minus one, so done fires on the N-th tick itself.
  assign o_done = i_en && i_tick && (r_count == i_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && i_tick) begin
      r_count <= r_count + Width'(1);
    end
  end

endmodule

// File: rtl/laser_controller.sv
// Laser shot sequencer: IDLE -> EXTEND -> HOLD -> COOLDOWN, all outputs registered.
// Optional early stop on hit while extending: define LASER_HIT_STOP_EN.
module laser_controller
  import laser_pkg::*;
#(
  parameter int unsigned R_MAX           = 15,
  parameter int unsigned STEP_FRAMES     = 2,
  parameter int unsigned HOLD_FRAMES     = 4,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input logic    clk,
  input logic    rst,
  laser_if.slave bus
);

  localparam int unsigned CntW = $clog2(max3(STEP_FRAMES, HOLD_FRAMES, COOLDOWN_FRAMES) + 1);

  localparam logic [CntW-1:0]          StepLast = CntW'(STEP_FRAMES - 1);
  localparam logic [CntW-1:0]          HoldLast = CntW'(HOLD_FRAMES - 1);
  localparam logic [CntW-1:0]          CoolLast = CntW'(COOLDOWN_FRAMES - 1);
  localparam logic [LASER_R_WIDTH-1:0] RMax     = LASER_R_WIDTH'(R_MAX);

  laser_state_t             r_state, w_state_d;
  logic                     r_active, w_active_d;
  logic [LASER_R_WIDTH-1:0] r_len, w_len_d;
  logic [1:0]               r_quad, w_quad_d;
  logic                     r_ready, w_ready_d;
  logic                     r_done, w_done_d;

  logic            w_cnt_done;
  logic            w_cnt_clear;
  logic [CntW-1:0] w_cnt_last;
  logic            w_hit_stop;

`ifdef LASER_HIT_STOP_EN
  assign w_hit_stop = bus.hit;
`else
  logic w_unused_hit;
  assign w_unused_hit = bus.hit;
  assign w_hit_stop   = 1'b0;
`endif

  always_comb begin
    w_cnt_last = StepLast;
    case (r_state)
      StHold:     w_cnt_last = HoldLast;
      StCooldown: w_cnt_last = CoolLast;
      default:    w_cnt_last = StepLast;
    endcase
  end

  // Count restarts on every state change and on every length step.
  assign w_cnt_clear = (w_state_d != r_state) || w_cnt_done;

  laser_frame_counter #(
    .Width (CntW)
  ) u_frame_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (r_state != StIdle),
    .i_tick  (bus.frame_tick),
    .i_clear (w_cnt_clear),
    .i_last  (w_cnt_last),
    .o_done  (w_cnt_done)
  );

  always_comb begin
    w_state_d  = r_state;
    w_active_d = r_active;
    w_len_d    = r_len;
    w_quad_d   = r_quad;
    w_done_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.fire) begin
          w_state_d  = StExtend;
          w_active_d = 1'b1;
          w_len_d    = '0;
          w_quad_d   = bus.quadrant_sel;
        end
      end
      StExtend: begin
        // A hit outranks a coincident step: length freezes where it is.
        if (w_hit_stop) begin
          w_state_d = StHold;
        end else if (w_cnt_done) begin
          if (r_len == RMax) begin
            w_state_d = StHold;
          end else begin
            w_len_d = r_len + LASER_R_WIDTH'(1);
          end
        end
      end
      StHold: begin
        if (w_cnt_done) begin
          w_state_d  = StCooldown;
          w_active_d = 1'b0;
          w_len_d    = '0;
          w_done_d   = 1'b1;
        end
      end
      StCooldown: begin
        if (w_cnt_done) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    w_ready_d = (w_state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_active <= 1'b0;
      r_len    <= '0;
      r_quad   <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_active <= w_active_d;
      r_len    <= w_len_d;
      r_quad   <= w_quad_d;
      r_ready  <= w_ready_d;
      r_done   <= w_done_d;
    end
  end

  assign bus.laser_active   = r_active;
  assign bus.laser_r        = r_len;
  assign bus.laser_quadrant = r_quad;
  assign bus.fire_ready     = r_ready;
  assign bus.shot_done      = r_done;

endmodule

// File: tb/tb_laser_controller.sv
// Directed scoreboard bench for laser_controller (default and R_MAX=1/STEP_FRAMES=1 instances).
module tb_laser_controller;
  import laser_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  laser_if bus_main ();
  laser_if bus_small ();

  laser_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_main)
  );

  laser_controller #(
    .R_MAX           (1),
    .STEP_FRAMES     (1),
    .HOLD_FRAMES     (4),
    .COOLDOWN_FRAMES (3)
  ) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_small)
  );

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  // Packed view: {active, laser_r, quadrant, fire_ready, shot_done}
  function automatic logic [8:0] mk(bit a, int r, logic [1:0] q, bit rdy, bit d);
    return {a, 4'(r), q, rdy, d};
  endfunction

  // Expected outputs after the k-th frame tick of a default-parameter shot.
  function automatic logic [8:0] shot_exp(int k, logic [1:0] q, bit gap);
    if (k <= 30) return mk(1'b1, k / 2, q, 1'b0, 1'b0);
    if (k <= 35) return mk(1'b1, 15, q, 1'b0, 1'b0);
    if (k == 36) return mk(1'b0, 0, q, 1'b0, !gap);
    if (k < 66)  return mk(1'b0, 0, q, 1'b0, 1'b0);
    return mk(1'b0, 0, q, 1'b1, 1'b0);
  endfunction

  task automatic drive(bit tick, bit fire, logic [1:0] qs, bit hit);
    bus_main.frame_tick    = tick;
    bus_main.fire          = fire;
    bus_main.quadrant_sel  = qs;
    bus_main.hit           = hit;
    bus_small.frame_tick   = tick;
    bus_small.fire         = fire;
    bus_small.quadrant_sel = qs;
    bus_small.hit          = hit;
  endtask

  task automatic push(string tag, logic [8:0] e);
    exp_t x;
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
  endtask

  task automatic check(bit sel);
    exp_t       e;
    logic [8:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e = sb.pop_front();
    if (sel)
      obs = {bus_small.laser_active, bus_small.laser_r, bus_small.laser_quadrant,
             bus_small.fire_ready, bus_small.shot_done};
    else
      obs = {bus_main.laser_active, bus_main.laser_r, bus_main.laser_quadrant,
             bus_main.fire_ready, bus_main.shot_done};
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  task automatic expect_now(string tag, bit sel, logic [8:0] e);
    push(tag, e);
    check(sel);
  endtask

  task automatic step(string tag, bit sel, bit tick, bit fire, logic [1:0] qs, bit hit,
                      logic [8:0] e);
    drive(tick, fire, qs, hit);
    push(tag, e);
    @(posedge clk);
    #1;
    bus_main.frame_tick  = 1'b0;
    bus_small.frame_tick = 1'b0;
    bus_main.hit         = 1'b0;
    bus_small.hit        = 1'b0;
    check(sel);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [8:0] e;
    checks = 0;
    errors = 0;
    drive(1'b0, 1'b0, 2'd0, 1'b0);

    // Reset state, then single-cycle fire with quadrant 2.
    do_reset();
    expect_now("reset_main", 1'b0, mk(1'b0, 0, 2'd0, 1'b1, 1'b0));
    step("fire_start", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, mk(1'b1, 0, 2'd2, 1'b0, 1'b0));

    // Full extension profile over 40 spaced ticks.
    for (int k = 1; k <= 40; k++) begin
      step($sformatf("ext_tick%0d", k), 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, shot_exp(k, 2'd2, 1'b0));
      step($sformatf("ext_gap%0d", k), 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, shot_exp(k, 2'd2, 1'b1));
    end

    // Fire held high and quadrant_sel toggling through shot and cooldown.
    do_reset();
    step("hold_fire_start", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, mk(1'b1, 0, 2'd1, 1'b0, 1'b0));
    for (int k = 1; k <= 66; k++) begin
      step($sformatf("held_tick%0d", k), 1'b0, 1'b1, 1'b1, 2'(k), 1'b0, shot_exp(k, 2'd1, 1'b0));
      if (k == 66) e = mk(1'b1, 0, 2'(k + 1), 1'b0, 1'b0);
      else         e = shot_exp(k, 2'd1, 1'b1);
      step($sformatf("held_gap%0d", k), 1'b0, 1'b0, 1'b1, 2'(k + 1), 1'b0, e);
    end

    // Hit coincident with the step tick at laser_r=5.
    do_reset();
    step("hit_fire", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, mk(1'b1, 0, 2'd3, 1'b0, 1'b0));
    for (int k = 1; k <= 11; k++) begin
      step($sformatf("hit_pre%0d", k), 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, shot_exp(k, 2'd3, 1'b0));
      step($sformatf("hit_pregap%0d", k), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, shot_exp(k, 2'd3, 1'b1));
    end
    for (int k = 12; k <= 16; k++) begin
`ifdef LASER_HIT_STOP_EN
      if (k < 16) e = mk(1'b1, 5, 2'd3, 1'b0, 1'b0);
      else        e = mk(1'b0, 0, 2'd3, 1'b0, 1'b1);
`else
      e = shot_exp(k, 2'd3, 1'b0);
`endif
      step($sformatf("hit_tick%0d", k), 1'b0, 1'b1, 1'b0, 2'd0, (k <= 15), e);
      e[0] = 1'b0;
      step($sformatf("hit_gap%0d", k), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, e);
    end

    // Asynchronous reset in the middle of HOLD, then a fresh shot.
    do_reset();
    step("ar_fire", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, mk(1'b1, 0, 2'd2, 1'b0, 1'b0));
    for (int k = 1; k <= 33; k++)
      step($sformatf("ar_tick%0d", k), 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, shot_exp(k, 2'd2, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    expect_now("ar_immediate", 1'b0, mk(1'b0, 0, 2'd0, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("ar_idle1", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, mk(1'b0, 0, 2'd0, 1'b1, 1'b0));
    step("ar_idle2", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, mk(1'b0, 0, 2'd0, 1'b1, 1'b0));
    step("ar_refire", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, mk(1'b1, 0, 2'd1, 1'b0, 1'b0));
    step("ar_t1", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, shot_exp(1, 2'd1, 1'b0));
    step("ar_t2", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, shot_exp(2, 2'd1, 1'b0));

    // R_MAX=1, STEP_FRAMES=1 instance: laser_r goes 0,1 then holds at 1.
    do_reset();
    expect_now("small_reset", 1'b1, mk(1'b0, 0, 2'd0, 1'b1, 1'b0));
    step("small_fire", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, mk(1'b1, 0, 2'd1, 1'b0, 1'b0));
    for (int k = 1; k <= 9; k++) begin
      if (k <= 5)      e = mk(1'b1, 1, 2'd1, 1'b0, 1'b0);
      else if (k == 6) e = mk(1'b0, 0, 2'd1, 1'b0, 1'b1);
      else if (k < 9)  e = mk(1'b0, 0, 2'd1, 1'b0, 1'b0);
      else             e = mk(1'b0, 0, 2'd1, 1'b1, 1'b0);
      step($sformatf("small_tick%0d", k), 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, e);
      e[0] = 1'b0;
      step($sformatf("small_gap%0d", k), 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
